scan_sequencer: RTL

Registered channel-scan controller that drives the 3-bit select and enable inputs of the 3-to-8 decoder stage directly downstream (`sel_out` to `data_in`, `en_out` to `enable`).
- Steps through the enabled channels in turn: dwell, then blank, then advance.
- Used for multiplexed display or peripheral-select scanning in the CPU board design.
- Guarantees a glitch-free, non-overlapping enable window per channel.

---
 rtl/scan_sequencer_pkg.sv | 57 +++++
 rtl/scan_sequencer_if.sv | 32 +++
 rtl/scan_sequencer_timer.sv | 51 +++++
 rtl/scan_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/scan_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared types, widths and the channel search helper for the scan sequencer.
//   state_e      : scan FSM states (IDLE, DWELL, BLANK)
//   SEL_W        : width of the channel index driven to the 3-to-8 decoder
//   CNT_W        : width of the dwell/blank interval counter
//   MAX_CH       : width of the channel mask
//   next_enabled : next enabled channel after 'cur', ascending or descending,
//                  wrapping inside 0..num_ch-1 (returns 'cur' itself when it
//                  is the only enabled channel)
// -----------------------------------------------------------------------------
package scan_pkg;

    localparam int SEL_W  = 3;
    localparam int CNT_W  = 16;
    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_e;

    // Walks at most num_ch steps away from 'cur' and returns the first
    // channel whose mask bit is set. The caller guarantees cur < num_ch.
    function automatic logic [SEL_W-1:0] next_enabled(
        input logic [MAX_CH-1:0] mask,
        input logic [SEL_W-1:0]  cur,
        input logic              desc,
        input int                num_ch
    );
        int               j;
        logic             found;
        logic [SEL_W-1:0] cand;
        logic [SEL_W-1:0] idx;
        idx   = cur;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            if (i <= num_ch && !found) begin
                if (desc) begin
                    j = int'(cur) - i;
                    if (j < 0) j = j + num_ch;
                end else begin
                    j = int'(cur) + i;
                    if (j >= num_ch) j = j - num_ch;
                end
                cand = SEL_W'(j);
                if (mask[cand]) begin
                    found = 1'b1;
                    idx   = cand;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// scan_sequencer_if
// Control and decoder-side signals of the scan sequencer.
//   run        : scan enable level                       (host -> sequencer)
//   ch_mask    : per-channel enable, bit i = channel i   (host -> sequencer)
//   dir        : 0 ascending, 1 descending; only when SCAN_DIR_EN is defined
//   sel_out    : channel index to decoder data_in        (sequencer -> host)
//   en_out     : decoder enable, high only while dwelling
//   frame_done : one-cycle pulse when the scan wraps to a new frame
// Modports: master = host/stimulus side, slave = scan_sequencer.
// -----------------------------------------------------------------------------
interface scan_sequencer_if;
    import scan_pkg::*;

    logic              run;
    logic [MAX_CH-1:0] ch_mask;
`ifdef SCAN_DIR_EN
    logic              dir;
`endif
    logic [SEL_W-1:0]  sel_out;
    logic              en_out;
    logic              frame_done;

`ifdef SCAN_DIR_EN
    modport master (output run, ch_mask, dir, input  sel_out, en_out, frame_done);
    modport slave  (input  run, ch_mask, dir, output sel_out, en_out, frame_done);
`else
    modport master (output run, ch_mask, input  sel_out, en_out, frame_done);
    modport slave  (input  run, ch_mask, output sel_out, en_out, frame_done);
`endif

endinterface

// File: rtl/scan_sequencer_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Loadable down-counter shared by the dwell and blank intervals. It stops at
// zero and flags it; the sequencer loads (length - 1) on entry to an interval
// and leaves the interval on the edge where zero_o is seen.
//   clk        : system clock
//   rst        : synchronous, active-high reset (count -> 0)
//   clr_i      : clear count to 0 (scan stopped)
//   load_i     : load load_val_i (takes precedence over counting)
//   load_val_i : value to load
//   zero_o     : count is zero
// -----------------------------------------------------------------------------
module scan_timer
    import scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: cnt_d is assigned a default first so no path through this block can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: reset is synchronous, so it is simply the highest-priority branch of the clocked block.
    // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
// Registered channel-scan controller driving a 3-to-8 decoder (sel_out ->
// data_in, en_out -> enable). Each enabled channel gets a dwell window of
// CLK_DIV cycles with en_out high, followed by BLANK_CYCLES cycles with en_out
// low, then the scan advances to the next enabled channel. sel_out only moves
// while en_out is low, except on IDLE entry/exit and when BLANK_CYCLES = 0.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : scan_sequencer_if.slave (run, ch_mask, [dir], sel_out, en_out,
//         frame_done)
// Parameters: CLK_DIV (1..65535), BLANK_CYCLES (0 = no gap), NUM_CH (1..8).
// Optional macro SCAN_DIR_EN: adds bus.dir; dir = 1 scans descending and
// starts from the highest enabled channel.
// -----------------------------------------------------------------------------
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int NUM_CH       = 8
) (
    input  logic             clk,
    input  logic             rst,
    scan_sequencer_if.slave  bus
);

    localparam logic [MAX_CH-1:0] CH_VALID   = MAX_CH'((1 << NUM_CH) - 1);
    localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LOAD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              en_q, en_d;
    logic              fd_q, fd_d;

    logic              tmr_clr;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero;

    logic              desc;
    logic              advance;
    logic [MAX_CH-1:0] eff_mask;
    logic [SEL_W-1:0]  first_idx;
    logic [SEL_W-1:0]  next_idx;
    logic              wrap;

`ifdef SCAN_DIR_EN
    assign desc = bus.dir;
`else
    assign desc = 1'b0;
`endif

    assign eff_mask  = bus.ch_mask & CH_VALID;
    // Searching from the far end lands on the lowest (ascending) or highest
    // (descending) enabled channel.
    assign first_idx = next_enabled(eff_mask, desc ? SEL_W'(0) : SEL_W'(NUM_CH - 1), desc, NUM_CH);
    assign next_idx  = next_enabled(eff_mask, sel_q, desc, NUM_CH);
    // A step that does not move in the scan direction has wrapped into a new frame.
    assign wrap      = desc ? (next_idx >= sel_q) : (next_idx <= sel_q);

    scan_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        en_d     = en_q;
        fd_d     = 1'b0;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = DWELL_LOAD;
        advance  = 1'b0;

        if (!bus.run) begin
            state_d = IDLE;
            sel_d   = '0;
            en_d    = 1'b0;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eff_mask != '0) begin
                        state_d  = DWELL;
                        sel_d    = first_idx;
                        en_d     = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
                DWELL: begin
                    if (tmr_zero) begin
                        if (BLANK_CYCLES == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d  = BLANK;
                            en_d     = 1'b0;
                            tmr_load = 1'b1;
                            tmr_val  = BLANK_LOAD;
                        end
                    end
                end
                BLANK: begin
                    if (tmr_zero) advance = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                    en_d    = 1'b0;
                    tmr_clr = 1'b1;
                end
            endcase

            // The mask (and direction) are sampled here, on the advance edge
            // only, so mid-dwell changes never cut a window short.
            if (advance) begin
                if (eff_mask == '0) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    en_d    = 1'b0;
                    tmr_clr = 1'b1;
                end else begin
                    state_d  = DWELL;
                    sel_d    = next_idx;
                    en_d     = 1'b1;
                    fd_d     = wrap;
                    tmr_load = 1'b1;
                    tmr_val  = DWELL_LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.sel_out    = sel_q;
    assign bus.en_out     = en_q;
    assign bus.frame_done = fd_q;

endmodule
